// File: rtl/dlx_mem_arbiter_pkg.sv
// Shared types and widths for the DLX unified-memory arbiter.
// Arbiter FSM states, default bus widths and the performance counter width.
package dlx_arb_pkg;

    localparam int DLX_ADDR_W = 32;
    localparam int DLX_DATA_W = 32;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IFETCH  = 2'd1,
        ARB_DACCESS = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and stall outputs of the arbiter.
// slave = arbiter side; master = pipeline/memory environment side.
interface dlx_mem_arbiter_if
    import dlx_arb_pkg::*;
#(
    parameter int ADDR_W = DLX_ADDR_W,
    parameter int DATA_W = DLX_DATA_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_pipe;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_pipe
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_pipe
    );

endinterface

// File: rtl/dlx_mem_arbiter_sat_counter.sv
// Saturating event counter: increments when i_en is high, sticks at all-ones, cleared by reset.
// Latency: count visible the cycle after the enabled cycle.
module arb_sat_counter
    import dlx_arb_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Single-port memory arbiter for DLX IF/MEM stages; data beats fetch, one grant at a time.
// Latency req->valid >= 2 cycles; stalls held while a request is unserved. Optional DLX_ARB_PERF_CNT_EN adds stall-cycle counters.
module dlx_mem_arbiter
    import dlx_arb_pkg::*;
#(
    parameter int ADDR_W = DLX_ADDR_W,
    parameter int DATA_W = DLX_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    dlx_mem_arbiter_if.slave      bus
`ifdef DLX_ARB_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_if_wait,
    output logic [PERF_CNT_W-1:0] perf_dm_wait
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_done_if;
    logic              w_done_dm;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dm_valid;
    logic [DATA_W-1:0] r_dm_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A requester whose valid is showing this cycle is being retired, not re-requesting.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_done_if   = 1'b0;
        w_done_dm   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (bus.dm_req && !r_dm_valid) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = ARB_DACCESS;
                end else if (bus.if_req && !r_if_valid) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = ARB_IFETCH;
                end
            end
            ARB_IFETCH: begin
                if (bus.mem_ack) begin
                    w_done_if   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_DACCESS: begin
                if (bus.mem_ack) begin
                    w_done_dm   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_valid  <= 1'b0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_valid <= w_done_if;
            r_dm_valid <= w_done_dm;
            if (w_grant_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.dm_we;
                r_mem_addr  <= bus.dm_addr;
                r_mem_wdata <= bus.dm_wdata;
            end else if (w_grant_if) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= bus.if_addr;
            end
            if (w_done_if) begin
                r_mem_req  <= 1'b0;
                r_if_rdata <= bus.mem_rdata;
            end
            if (w_done_dm) begin
                r_mem_req <= 1'b0;
                // Stores leave the last load value in place.
                if (!r_mem_we) begin
                    r_dm_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.if_valid   = r_if_valid;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.dm_valid   = r_dm_valid;
    assign bus.dm_rdata   = r_dm_rdata;
    assign bus.stall_if   = bus.if_req && !r_if_valid;
    assign bus.stall_pipe = bus.dm_req && !r_dm_valid;

`ifdef DLX_ARB_PERF_CNT_EN
    arb_sat_counter #(.W(PERF_CNT_W)) u_if_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (bus.if_req && !r_if_valid),
        .o_cnt (perf_if_wait)
    );

    arb_sat_counter #(.W(PERF_CNT_W)) u_dm_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (bus.dm_req && !r_dm_valid),
        .o_cnt (perf_dm_wait)
    );
`endif

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter: fetch, priority, load path, zero-wait alternation, reset mid-access.
module tb_dlx_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dlx_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

`ifdef DLX_ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_dm_wait;
`endif

    dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if.slave)
`ifdef DLX_ARB_PERF_CNT_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Enter the next cycle just after its rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_dv;
        logic [7:0] exp_iv;
        logic [31:0] exp_addr [0:7];
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_if.if_req    = 1'b0;
        bus_if.if_addr   = '0;
        bus_if.dm_req    = 1'b0;
        bus_if.dm_we     = 1'b0;
        bus_if.dm_addr   = '0;
        bus_if.dm_wdata  = '0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;

        // Reset state
        cyc(); cyc(); smp();
        chk("rst_mem_req",  {31'd0, bus_if.mem_req},  32'd0);
        chk("rst_mem_we",   {31'd0, bus_if.mem_we},   32'd0);
        chk("rst_if_valid", {31'd0, bus_if.if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, bus_if.dm_valid}, 32'd0);
        chk("rst_mem_addr", bus_if.mem_addr,  32'd0);
        chk("rst_mem_wdat", bus_if.mem_wdata, 32'd0);
        chk("rst_if_rdata", bus_if.if_rdata,  32'd0);
        chk("rst_dm_rdata", bus_if.dm_rdata,  32'd0);
`ifdef DLX_ARB_PERF_CNT_EN
        chk("rst_perf_if", perf_if_wait, 32'd0);
        chk("rst_perf_dm", perf_dm_wait, 32'd0);
`endif
        cyc(); reset = 1'b0;

        // Single fetch, memory acks two cycles after mem_req rises
        cyc(); bus_if.if_req = 1'b1; bus_if.if_addr = 32'h10; smp();
        chk("f_c0_stall_if", {31'd0, bus_if.stall_if}, 32'd1);
        chk("f_c0_mem_req",  {31'd0, bus_if.mem_req},  32'd0);
        cyc(); smp();
        chk("f_c1_mem_req",  {31'd0, bus_if.mem_req},  32'd1);
        chk("f_c1_mem_addr", bus_if.mem_addr, 32'h10);
        chk("f_c1_mem_we",   {31'd0, bus_if.mem_we},   32'd0);
        cyc(); smp();
        chk("f_c2_if_valid", {31'd0, bus_if.if_valid}, 32'd0);
        chk("f_c2_stall_if", {31'd0, bus_if.stall_if}, 32'd1);
        cyc(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h2000_0015; smp();
        chk("f_c3_if_valid", {31'd0, bus_if.if_valid}, 32'd0);
        chk("f_c3_mem_req",  {31'd0, bus_if.mem_req},  32'd1);
        cyc(); bus_if.mem_ack = 1'b0; smp();
        chk("f_c4_if_valid", {31'd0, bus_if.if_valid}, 32'd1);
        chk("f_c4_if_rdata", bus_if.if_rdata, 32'h2000_0015);
        chk("f_c4_stall_if", {31'd0, bus_if.stall_if}, 32'd0);
        chk("f_c4_mem_req",  {31'd0, bus_if.mem_req},  32'd0);
        cyc(); bus_if.if_req = 1'b0; smp();
        chk("f_c5_if_valid", {31'd0, bus_if.if_valid}, 32'd0);
        chk("f_c5_mem_req",  {31'd0, bus_if.mem_req},  32'd0);

        // Priority: store beats simultaneous fetch, fetch follows after one bubble
        cyc();
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h20;
        bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b1;
        bus_if.dm_addr = 32'h100; bus_if.dm_wdata = 32'hDEAD_BEEF;
        smp();
        chk("p_c0_stall_pipe", {31'd0, bus_if.stall_pipe}, 32'd1);
        cyc(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h3333_3333; smp();
        chk("p_c1_mem_req",  {31'd0, bus_if.mem_req}, 32'd1);
        chk("p_c1_mem_we",   {31'd0, bus_if.mem_we},  32'd1);
        chk("p_c1_mem_addr", bus_if.mem_addr,  32'h100);
        chk("p_c1_mem_wdat", bus_if.mem_wdata, 32'hDEAD_BEEF);
        chk("p_c1_stall_if", {31'd0, bus_if.stall_if}, 32'd1);
        cyc(); bus_if.mem_ack = 1'b0; smp();
        chk("p_c2_dm_valid",   {31'd0, bus_if.dm_valid},   32'd1);
        chk("p_c2_mem_req",    {31'd0, bus_if.mem_req},    32'd0);
        chk("p_c2_stall_pipe", {31'd0, bus_if.stall_pipe}, 32'd0);
        chk("p_c2_dm_rdata",   bus_if.dm_rdata, 32'd0);
        cyc(); bus_if.dm_req = 1'b0; bus_if.dm_we = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h1111_1111; smp();
        chk("p_c3_mem_req",  {31'd0, bus_if.mem_req}, 32'd1);
        chk("p_c3_mem_addr", bus_if.mem_addr, 32'h20);
        chk("p_c3_mem_we",   {31'd0, bus_if.mem_we},  32'd0);
        chk("p_c3_dm_valid", {31'd0, bus_if.dm_valid}, 32'd0);
        cyc(); bus_if.mem_ack = 1'b0; smp();
        chk("p_c4_if_valid", {31'd0, bus_if.if_valid}, 32'd1);
        chk("p_c4_if_rdata", bus_if.if_rdata, 32'h1111_1111);
        chk("p_c4_dm_rdata", bus_if.dm_rdata, 32'd0);
        cyc(); bus_if.if_req = 1'b0;

        // Load data path
        cyc(); bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b0; bus_if.dm_addr = 32'h40;
        cyc(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h0000_0007; smp();
        chk("l_c1_mem_addr", bus_if.mem_addr, 32'h40);
        chk("l_c1_mem_we",   {31'd0, bus_if.mem_we}, 32'd0);
        cyc(); bus_if.mem_ack = 1'b0; smp();
        chk("l_c2_dm_valid", {31'd0, bus_if.dm_valid}, 32'd1);
        chk("l_c2_dm_rdata", bus_if.dm_rdata, 32'h0000_0007);
        chk("l_c2_if_rdata", bus_if.if_rdata, 32'h1111_1111);
        cyc(); bus_if.dm_req = 1'b0; smp();
        chk("l_c3_dm_valid", {31'd0, bus_if.dm_valid}, 32'd0);

        // Zero-wait memory, data and fetch alternating: valids on cycles 2,4,6,8
        cyc();
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h200;
        bus_if.dm_req = 1'b1; bus_if.dm_addr = 32'h300;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h0BAD_F00D;
        exp_dv = 8'b0010_0010;
        exp_iv = 8'b1000_1000;
        exp_addr[0] = 32'h300; exp_addr[2] = 32'h200;
        exp_addr[4] = 32'h304; exp_addr[6] = 32'h204;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 3) bus_if.dm_addr = 32'h304;
            if (k == 5) bus_if.if_addr = 32'h204;
            if (k == 7) bus_if.dm_req = 1'b0;
            smp();
            chk($sformatf("z_c%0d_dm_valid", k), {31'd0, bus_if.dm_valid}, {31'd0, exp_dv[k-1]});
            chk($sformatf("z_c%0d_if_valid", k), {31'd0, bus_if.if_valid}, {31'd0, exp_iv[k-1]});
            chk($sformatf("z_c%0d_mem_req", k),  {31'd0, bus_if.mem_req},  {31'd0, k[0]});
            if (k[0]) chk($sformatf("z_c%0d_mem_addr", k), bus_if.mem_addr, exp_addr[k-1]);
        end
        chk("z_c8_if_rdata", bus_if.if_rdata, 32'h0BAD_F00D);
        cyc(); bus_if.if_req = 1'b0; bus_if.mem_ack = 1'b0; smp();
        chk("z_c9_mem_req", {31'd0, bus_if.mem_req}, 32'd0);

        // Reset mid-access, then a late ack after release
        cyc(); bus_if.dm_req = 1'b1; bus_if.dm_addr = 32'h80;
        cyc(); smp();
        chk("r_c1_mem_req", {31'd0, bus_if.mem_req}, 32'd1);
        cyc(); #2 reset = 1'b1; #1;
        chk("r_async_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        bus_if.dm_req = 1'b0;
        cyc(); #2 reset = 1'b0;
        cyc(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h0000_0055;
        cyc(); bus_if.mem_ack = 1'b0; smp();
        chk("r_dm_valid", {31'd0, bus_if.dm_valid}, 32'd0);
        chk("r_if_valid", {31'd0, bus_if.if_valid}, 32'd0);
        chk("r_mem_req",  {31'd0, bus_if.mem_req},  32'd0);
        chk("r_dm_rdata", bus_if.dm_rdata, 32'd0);
        cyc(); bus_if.if_req = 1'b1; bus_if.if_addr = 32'h64;
        cyc(); smp();
        chk("r_idle_grant_req",  {31'd0, bus_if.mem_req}, 32'd1);
        chk("r_idle_grant_addr", bus_if.mem_addr, 32'h64);
        bus_if.mem_ack = 1'b1;
        cyc(); bus_if.mem_ack = 1'b0;
        cyc(); bus_if.if_req = 1'b0;

`ifdef DLX_ARB_PERF_CNT_EN
        // Load acked on its 3rd mem_req cycle, fetch on its 4th: dm waits 4, fetch waits 9
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        cyc();
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h48;
        bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b0; bus_if.dm_addr = 32'h44;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            bus_if.mem_ack = (k == 3 || k == 8);
            if (k == 5)  bus_if.dm_req = 1'b0;
            if (k == 10) bus_if.if_req = 1'b0;
        end
        smp();
        chk("perf_dm_wait", perf_dm_wait, 32'd4);
        chk("perf_if_wait", perf_if_wait, 32'd9);
        cyc(); reset = 1'b1; smp();
        chk("perf_dm_clr", perf_dm_wait, 32'd0);
        chk("perf_if_clr", perf_if_wait, 32'd0);
        cyc(); reset = 1'b0;
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
